// File: rtl/lab4_serial_engine.sv
// LAB4 serial config engine: shifts a word MSB-first to one or all chips, pulses PCLK, captures SHOUT.
// Latency (2*DATA_BITS+1)*(P+1) cycles from accept to done; busy_o high means requests are ignored.
module lab4_serial_engine #(
  parameter int NUM_LAB       = 12,
  parameter int DATA_BITS     = 24,
  parameter int PRESCALE_BITS = 8,
  parameter int SEL_BITS      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     req_i,
  input  logic [DATA_BITS-1:0]     data_i,
  input  logic [SEL_BITS-1:0]      sel_i,
  input  logic                     broadcast_i,
  input  logic [PRESCALE_BITS-1:0] prescale_i,
  input  logic [NUM_LAB-1:0]       SHOUT,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [DATA_BITS-1:0]     readback_o,
  output logic [NUM_LAB-1:0]       SIN,
  output logic [NUM_LAB-1:0]       SCLK,
  output logic [NUM_LAB-1:0]       PCLK
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, SCLK_LO, SCLK_HI, LATCH} state_t;

  state_t                   state_q, state_d;
  logic [PRESCALE_BITS-1:0] cnt_q, cnt_d, pre_q, pre_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]     data_q, data_d, shift_q, shift_d, rdbk_q, rdbk_d;
  logic [SEL_BITS-1:0]      sel_q, sel_d;
  logic                     bc_q, bc_d;
  logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [NUM_LAB-1:0]       sin_q, sin_d, sclk_q, sclk_d, pclk_q, pclk_d;
  logic [NUM_LAB-1:0]       mask_d;
  logic [SEL_BITS-1:0]      rb_sel;
  logic                     rb_bit, sel_ok, last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    bit_d   = bit_q;
    data_d  = data_q;
    sel_d   = sel_q;
    bc_d    = bc_q;
    shift_d = shift_q;
    rdbk_d  = rdbk_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Broadcast transactions read back from chip 0.
    rb_sel = bc_q ? '0 : sel_q;
    rb_bit = 1'b0;
    for (int i = 0; i < NUM_LAB; i++) begin
      if (rb_sel == SEL_BITS'(i)) rb_bit = SHOUT[i];
    end

    sel_ok = broadcast_i || ({1'b0, sel_i} < (SEL_BITS+1)'(NUM_LAB));
    last   = (cnt_q == pre_q);

    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (sel_ok) begin
            state_d = SCLK_LO;
            cnt_d   = '0;
            pre_d   = prescale_i;
            bit_d   = BIT_W'(DATA_BITS-1);
            data_d  = data_i;
            sel_d   = sel_i;
            bc_d    = broadcast_i;
            shift_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCLK_LO: begin
        if (last) begin
          cnt_d   = '0;
          state_d = SCLK_HI;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCLK_HI: begin
        if (cnt_q == '0) shift_d = {shift_q[DATA_BITS-2:0], rb_bit};
        if (last) begin
          cnt_d = '0;
          if (bit_q == '0) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = SCLK_LO;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (last) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          rdbk_d  = shift_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs are decoded from next state so they register alongside it.
    for (int i = 0; i < NUM_LAB; i++) begin
      mask_d[i] = bc_d || (sel_d == SEL_BITS'(i));
    end
    busy_d = (state_d != IDLE);
    sin_d  = ((state_d == SCLK_LO || state_d == SCLK_HI) && data_d[bit_d]) ? mask_d : '0;
    sclk_d = (state_d == SCLK_HI) ? mask_d : '0;
    pclk_d = (state_d == LATCH) ? mask_d : '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      bc_q    <= 1'b0;
      shift_q <= '0;
      rdbk_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sin_q   <= '0;
      sclk_q  <= '0;
      pclk_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      rdbk_q  <= rdbk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sin_q   <= sin_d;
      sclk_q  <= sclk_d;
      pclk_q  <= pclk_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign readback_o = rdbk_q;
  assign SIN        = sin_q;
  assign SCLK       = sclk_q;
  assign PCLK       = pclk_q;

endmodule

// File: tb/tb_lab4_serial_engine.sv
// Bench for lab4_serial_engine: directed writes, scoreboard on done/err, pin probe per transaction.
module tb_lab4_serial_engine;
  localparam int NL = 12;
  localparam int DB = 24;
  localparam int PB = 8;
  localparam int SB = 4;
  // SHOUT is SIN delayed one cycle; chip 0 is inverted so broadcast readback is distinguishable.
  localparam logic [NL-1:0] INV = 12'h001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          bc = 1'b0;
  logic [DB-1:0] data = '0;
  logic [SB-1:0] sel = '0;
  logic [PB-1:0] pre = '0;
  logic [NL-1:0] shout, sin, sclk, pclk;
  logic [NL-1:0] sin_d = '0;
  logic          busy, done, err;
  logic [DB-1:0] rdbk;

  lab4_serial_engine #(.NUM_LAB(NL), .DATA_BITS(DB), .PRESCALE_BITS(PB), .SEL_BITS(SB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .data_i(data), .sel_i(sel),
    .broadcast_i(bc), .prescale_i(pre), .SHOUT(shout), .busy_o(busy), .done_o(done),
    .err_o(err), .readback_o(rdbk), .SIN(sin), .SCLK(sclk), .PCLK(pclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sin_d <= sin;
  assign shout = sin_d ^ INV;

  int checks = 0;
  int failures = 0;

  typedef struct {bit is_err; logic [DB-1:0] rb; int busy;} exp_t;
  exp_t q[$];
  exp_t me;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expectation per done_o or err_o pulse.
  int bcnt = 0;
  always @(negedge clk) begin
    if (err) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_err actual=1 required=0");
      end else begin
        me = q.pop_front();
        chk("err_kind", 64'(me.is_err), 64'd1);
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        me = q.pop_front();
        chk("done_kind", 64'(me.is_err), 64'd0);
        chk("readback", 64'(rdbk), 64'(me.rb));
        chk("busy_len", 64'(bcnt), 64'(me.busy));
      end
    end
    if (busy) bcnt++;
    else bcnt = 0;
  end

  // Pin probe for one chip plus activity/uniformity of the rest.
  logic [3:0]    pc = '0;
  logic [NL-1:0] pmask = '0;
  bit            pbc = 1'b0;
  logic [DB-1:0] cap = '0;
  int            nbits = 0, pcl = 0;
  bit            other = 1'b0, bcbad = 1'b0;
  logic          sprev = 1'b0;
  always @(negedge clk) begin
    if (sclk[pc] && !sprev) begin
      cap = {cap[DB-2:0], sin[pc]};
      nbits++;
    end
    sprev = sclk[pc];
    if (pclk[pc]) pcl++;
    if (((sin | sclk | pclk) & ~pmask) != '0) other = 1'b1;
    if (pbc && ((sclk != '0 && sclk != '1) || (pclk != '0 && pclk != '1) ||
                (sin != '0 && sin != '1))) bcbad = 1'b1;
  end

  task automatic probe_reset(input int c, input logic [NL-1:0] m, input bit b);
    pc = 4'(c); pmask = m; pbc = b;
    cap = '0; nbits = 0; pcl = 0; other = 1'b0; bcbad = 1'b0; sprev = 1'b0;
  endtask

  task automatic issue(input logic [DB-1:0] d, input int s, input bit b, input int p);
    @(negedge clk);
    data = d; sel = SB'(s); bc = b; pre = PB'(p); req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic check_xfer(input string name, input logic [DB-1:0] bits, input int npclk, input int nb);
    chk({name, "_nbits"}, 64'(nbits), 64'(nb));
    chk({name, "_sin"}, 64'(cap), 64'(bits));
    chk({name, "_pclk"}, 64'(pcl), 64'(npclk));
    chk({name, "_others"}, 64'(other), 64'd0);
  endtask

  initial begin
    bit saw;
    int k;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_pins", 64'(sin | sclk | pclk), 64'd0);
    chk("rst_readback", 64'(rdbk), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Targeted write, P=0.
    probe_reset(3, 12'h008, 1'b0);
    q.push_back('{1'b0, 24'hA5C3F0, 49});
    issue(24'hA5C3F0, 3, 1'b0, 0);
    wait_done("t1", 200);
    check_xfer("t1", 24'hA5C3F0, 1, 24);

    // Same word with loopback readback, P=2.
    probe_reset(3, 12'h008, 1'b0);
    q.push_back('{1'b0, 24'hA5C3F0, 147});
    issue(24'hA5C3F0, 3, 1'b0, 2);
    wait_done("t2", 400);
    check_xfer("t2", 24'hA5C3F0, 3, 24);

    // Broadcast with out-of-range sel; readback comes from inverted chip 0.
    probe_reset(0, '1, 1'b1);
    q.push_back('{1'b0, 24'hFFFFFE, 49});
    issue(24'h000001, 15, 1'b1, 0);
    wait_done("t3", 200);
    check_xfer("t3", 24'h000001, 1, 24);
    chk("t3_uniform", 64'(bcbad), 64'd0);

    // Rejected request.
    probe_reset(0, '0, 1'b0);
    q.push_back('{1'b1, 24'h0, 0});
    issue(24'hFFFFFF, 12, 1'b0, 0);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    chk("err_busy", 64'(saw), 64'd0);
    chk("err_activity", 64'(other), 64'd0);
    chk("err_popped", 64'(q.size()), 64'd0);

    // Reset at bit 10 of a P=3 write, then a clean write to chip 0.
    probe_reset(5, 12'h020, 1'b0);
    issue(24'h123456, 5, 1'b0, 3);
    k = 0;
    while (nbits < 14 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("rst_mid_bit", 64'(nbits), 64'd14);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_pins", 64'(sin | sclk | pclk), 64'd0);
    chk("rstmid_readback", 64'(rdbk), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    probe_reset(0, 12'h001, 1'b0);
    q.push_back('{1'b0, 24'hF0F0F0, 196});
    issue(24'h0F0F0F, 0, 1'b0, 3);
    wait_done("t5", 400);
    check_xfer("t5", 24'h0F0F0F, 4, 24);

    // Back-to-back with req held, P=255; data_i changes mid-transaction.
    probe_reset(3, 12'h008, 1'b0);
    q.push_back('{1'b0, 24'h111111, 12544});
    q.push_back('{1'b0, 24'h222222, 12544});
    @(negedge clk);
    data = 24'h111111; sel = 4'd3; bc = 1'b0; pre = 8'd255; req = 1'b1;
    @(negedge clk);
    data = 24'h222222;
    wait_done("b2b_first", 13000);
    @(negedge clk);
    chk("b2b_rebusy", 64'(busy), 64'd1);
    req = 1'b0;
    wait_done("b2b_second", 13000);
    check_xfer("b2b", 24'h222222, 512, 48);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
